// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 800x600@60 raster timing source with registered, aligned strobes.
//            Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_H_MAX    = 11'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_MAX    = 10'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [9:0]  c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] c_HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  c_VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;

    logic [10:0] w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_wrap;

    // Strobes are decoded from the next counter values so that, once
    // registered, they describe the same raster point as the counters.
    always_comb begin
        w_h_last = (r_hcount == c_H_MAX);
        w_v_last = (r_vcount == c_V_MAX);
        w_wrap   = w_h_last & w_v_last;
        w_h_nxt  = w_h_last ? 11'd0 : r_hcount + 11'd1;
        w_v_nxt  = r_vcount;
        if (w_h_last) begin
            w_v_nxt = w_v_last ? 10'd0 : r_vcount + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 10'd0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hcount      <= w_h_nxt;
            r_vcount      <= w_v_nxt;
            r_hblnk       <= (w_h_nxt >= c_H_ACT);
            r_vblnk       <= (w_v_nxt >= c_V_ACT);
            r_hsync       <= (w_h_nxt >= c_HS_FIRST) && (w_h_nxt <= c_HS_LAST);
            r_vsync       <= (w_v_nxt >= c_VS_FIRST) && (w_v_nxt <= c_VS_LAST);
            r_frame_start <= w_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_cnt <= 16'd0;
        end else if (en && w_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign hcount_out  = r_hcount;
    assign vcount_out  = r_vcount;
    assign hblnk_out   = r_hblnk;
    assign vblnk_out   = r_vblnk;
    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
